// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice and a carry flop reused each clock, {cout,sum} = a + b + cin.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+WIDTH; busy high for WIDTH cycles.
// Backpressure: start is ignored while busy; it is accepted in IDLE or in the DONE cycle, so back-to-back results arrive every WIDTH+1 cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             s;
    logic             carry_next;
    logic             busy_next;
    logic             done_next;

    // A new operation can only be taken when no addition is in flight.
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST_BIT);

    // The single full-adder slice working on the current LSBs.
    always_comb begin
        s          = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE behaves like IDLE for start so operations can run back-to-back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state, so busy/done can be registered without a comb path to the ports.
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Datapath: load operands on accept, then shift one bit per cycle; publish result on the last bit only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {s, res_sr[WIDTH-1:1]};
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= {s, res_sr[WIDTH-1:1]};
                cout <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed cases against a cycle model, WIDTH=4 exhaustive.
// Latency: done expected WIDTH cycles after busy rises.
// Backpressure: start pulses while busy must be ignored.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a countdown of busy cycles and the arithmetic result taken at acceptance.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum  = 8'h00;
    logic       m_cout = 1'b0;
    logic [8:0] m_pend = 9'h000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= 8'h00;
            m_cout <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                {m_cout, m_sum} <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= 9'(a) + 9'(b) + 9'(cin);
                m_left <= 8;
            end
        end
    end

    // Compare the WIDTH=8 instance against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", busy, (m_left > 0) ? 1 : 0);
            check("cyc_done", done, m_done);
            check("cyc_sum", sum, m_sum);
            check("cyc_cout", cout, m_cout);
        end
    end

    // Directed single operation with literal expectations and latency/holding checks.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic ec, input string nm);
        int k;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check({nm, "_busy_rise"}, busy, 1);
            end
        end while (!done && k < 40);
        check({nm, "_latency"}, k, 9);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
        @(negedge clk);
        check({nm, "_done_fall"}, done, 0);
        check({nm, "_sum_hold"}, sum, es);
        check({nm, "_cout_hold"}, cout, ec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dones;
        logic [4:0] exp4;
        start = 0; a = 0; b = 0; cin = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        cmp_en = 1;

        run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "chain");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "all_ones");

        // start while busy is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 0; start = 1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) start = 0;
            if (k == 3) begin a = 8'hAA; b = 8'h55; start = 1; end
            if (k == 4) start = 0;
        end while (!done && k < 40);
        check("ign_latency", k, 9);
        check("ign_sum", sum, 8'h30);
        check("ign_cout", cout, 0);
        repeat (3) @(negedge clk);
        check("ign_no_second", busy, 0);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 0; start = 1;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 40);
        check("b2b_first_sum", sum, 8'h03);
        check("b2b_first_cout", cout, 0);
        a = 8'h80; b = 8'h80;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 40);
        check("b2b_gap", k, 9);
        check("b2b_second_sum", sum, 8'h00);
        check("b2b_second_cout", cout, 1);
        start = 0;
        repeat (2) @(negedge clk);
        check("b2b_stop", busy, 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("arst_no_done", dones, 0);
        run_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "after_rst");

        // exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1;
            exp4 = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) start4 = 0;
            end while (!done4 && k < 40);
            check("w4_latency", k, 5);
            check("w4_result", {cout4, sum4}, exp4);
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB-first. It is the additive counterpart of the team's combinational full subtractor cell.
- Operands load in parallel on a start handshake. One full-adder slice plus a registered carry is reused each clock, one bit per cycle.
- The result is presented in parallel with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in slow control paths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled on rising clk edge
- a      input   WIDTH  operand A; captured when start is accepted
- b      input   WIDTH  operand B; captured when start is accepted
- cin    input   1      carry-in; captured when start is accepted
- busy   output  1      high while an addition is in progress
- done   output  1      one-cycle pulse; sum/cout valid from this cycle
- sum    output  WIDTH  registered result, held until next done
- cout   output  1      registered carry-out, held until next done

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - FSM goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and bit counter are cleared.
  - No done pulse is ever produced for an operation interrupted by reset.
- FSM states: IDLE, RUN, DONE. All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE:
  - start=1 at an edge: capture a into shift register A_sr, b into B_sr, cin into carry reg, clear counter to 0, go to RUN, busy=1 from the next cycle.
  - start=0: stay in IDLE.
- RUN, each edge:
  - s = A_sr[0] ^ B_sr[0] ^ carry
  - carry <= (A_sr[0]&B_sr[0]) | (A_sr[0]&carry) | (B_sr[0]&carry)
  - A_sr and B_sr shift right one place.
  - s enters the result shift register at the MSB; that register shifts right.
  - counter increments.
  - On the edge where counter == WIDTH-1 (the last bit is processed), additionally:
    - sum <= final shift-register value with the last bit at the MSB
    - cout <= carry-out of that bit
    - done <= 1, busy <= 0
    - go to DONE
- DONE: lasts exactly one cycle with done=1.
  - start=1 at the DONE edge: accepted exactly as in IDLE (back-to-back operations).
  - Otherwise go to IDLE; done returns to 0.
- start while busy=1 (RUN) is ignored. Captured operands are unaffected and a, b, cin may change freely during RUN.
- Latency:
  - start sampled at edge E0.
  - done=1 in the cycle following edge E0+WIDTH, i.e. WIDTH cycles after busy rises.
  - busy is high for exactly WIDTH cycles.
  - Throughput is one result per WIDTH+1 cycles back-to-back.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No overflow flag; signed overflow is the user's responsibility.
- sum/cout keep the previous result during RUN and change only in the cycle done asserts.

Test Plan (WIDTH=8 unless noted):
- Basic add: a=8'h3C, b=8'h05, cin=0, start pulsed 1 cycle.
  -> busy high 8 cycles, then done=1 for 1 cycle with sum=8'h41, cout=0; sum/cout hold afterwards.
- Carry chain and carry-in:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start ignored while busy: start a=8'h10, b=8'h20, then 3 cycles later start=1 with a=8'hAA, b=8'h55.
  -> a single done with sum=8'h30, cout=0; no second operation begins.
- Back-to-back: start held high continuously with a=8'h01, b=8'h02, changed to a=8'h80, b=8'h80 in the DONE cycle.
  -> done pulses 9 cycles apart; results 8'h03/cout=0, then 8'h00/cout=1.
- Reset mid-operation: start a=8'h7F, b=8'h01; assert rst_n=0 asynchronously (not on a clock edge) after 4 cycles.
  -> busy, done, sum, cout go to 0 immediately; after release, no done appears until a new start.
  -> A new start with a=8'h02, b=8'h03 then gives sum=8'h05.
- Exhaustive (WIDTH=4): all 512 combinations of a, b, cin.
  -> {cout,sum} == a+b+cin in every case; each done occurs exactly 4 cycles after busy rises.
